// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM state encoding (IDLE / SHIFT / FIN)
//   WIDTH_DEFAULT  : default operand width
//   cnt_width()    : bit-counter width for a given operand width, clog2(WIDTH+1)
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FIN   = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Counter is sized to hold WIDTH itself so any legal WIDTH (2..32) fits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_sub_1bit.sv
// One-bit full subtractor: D = A - B - Bin, Bout = borrow out.
//   A, B, Bin : operand bits and borrow in
//   D, Bout   : difference bit and borrow out
module full_sub_1bit (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: DIFF = A - B - BIN (mod 2^WIDTH), one bit per cycle.
//   CLK, RST        : clock, asynchronous active-high reset
//   START           : begin an operation (only honoured while idle)
//   A, B, BIN       : operands and borrow-in, captured when START is accepted
//   DIFF, BOUT      : registered result and borrow-out, updated only in FIN
//   BUSY            : high in SHIFT and FIN
//   DONE            : one-cycle pulse when DIFF/BOUT become valid
// Timing: START taken on edge 0, SHIFT runs edges 1..WIDTH, FIN registers
// the result on edge WIDTH+1, so DONE is high the cycle after that edge.
module serial_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit, br_next;
  logic             last_bit;

  full_sub_1bit u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (br),
    .D    (d_bit),
    .Bout (br_next)
  );

  // cnt counts shifts already completed; the WIDTH-th shift ends SHIFT.
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign BUSY     = (state != S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (START) state_next = S_SHIFT;
      S_SHIFT: if (last_bit) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      DIFF   <= '0;
      BOUT   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (START) begin
            a_sr <= A;
            b_sr <= B;
            br   <= BIN;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          // Difference bits enter at the MSB so after WIDTH shifts the
          // LSB-first result sits in natural bit order.
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
        end
        S_FIN: begin
          DIFF <= res_sr;
          BOUT <= br;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BIN = 1'b0;
  logic [W-1:0] DIFF;
  logic         BOUT, BUSY, DONE;

  int n_checks = 0;
  int n_pass   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BIN(BIN),
    .DIFF(DIFF), .BOUT(BOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain unsigned arithmetic on wide integers.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bin);
    longint d;
    d = longint'(a) - longint'(b) - longint'(bin);
    return W'(d & ((64'd1 << W) - 1));
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] a, b, input logic bin);
    return longint'(a) < (longint'(b) + longint'(bin));
  endfunction

  // One full operation; operands are scrambled while it runs to show that
  // only the captured values matter.
  task automatic run_op(input logic [W-1:0] a, b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input string tag);
    logic [W-1:0] prev;
    int  edges;
    bit  stable, seen;
    @(negedge CLK);
    A = a; B = b; BIN = bin; START = 1'b1;
    prev = DIFF;
    @(posedge CLK);
    edges = 0; stable = 1'b1; seen = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    check({tag, " busy"}, 32'(BUSY), 32'd1);
    for (int k = 0; k < 4*W && !seen; k++) begin
      A = W'($urandom); B = W'($urandom); BIN = 1'($urandom);
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (DONE) seen = 1'b1;
      else if (DIFF !== prev) stable = 1'b0;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, 32'(edges), 32'(W + 1));
      check({tag, " diff"}, 32'(DIFF), 32'(ed));
      check({tag, " bout"}, 32'(BOUT), 32'(eb));
      check({tag, " hold_in_shift"}, 32'(stable), 32'd1);
      @(negedge CLK);
      check({tag, " done_one_cycle"}, 32'(DONE), 32'd0);
    end
  endtask

  initial begin
    vec_t         tbl[4];
    logic [W-1:0] ra, rb, got;
    logic         rbin;
    int           ndone, lows;
    int           dones[$];
    bit           lowv[int];

    tbl[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset diff", 32'(DIFF), 32'd0);
    check("reset bout", 32'(BOUT), 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset done", 32'(DONE), 32'd0);
    RST = 1'b0;

    // Directed table
    foreach (tbl[i])
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].exp_diff, tbl[i].exp_bout,
             $sformatf("vec%0d", i));

    // Random against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (i == 0) begin ra = '0; rb = '1; rbin = 1'b1; end
      run_op(ra, rb, rbin, ref_diff(ra, rb, rbin), ref_bout(ra, rb, rbin),
             $sformatf("rnd%0d", i));
    end

    // START while busy is ignored
    @(negedge CLK);
    A = 8'h10; B = 8'h01; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); A = 8'h00; B = 8'h00; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    ndone = 0; got = '0;
    for (int k = 0; k < 3*W; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin ndone++; got = DIFF; end
    end
    check("ignore done_count", 32'(ndone), 32'd1);
    check("ignore diff", 32'(got), 32'h0F);
    check("ignore idle_after", 32'(BUSY), 32'd0);

    // Asynchronous reset mid-operation
    @(negedge CLK);
    A = 8'h55; B = 8'h22; BIN = 1'b0; START = 1'b1;
    @(posedge CLK);
    @(negedge CLK); START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst busy", 32'(BUSY), 32'd0);
    check("rst diff", 32'(DIFF), 32'd0);
    check("rst bout", 32'(BOUT), 32'd0);
    check("rst done", 32'(DONE), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    for (int k = 0; k < 2*W; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) ndone++;
    end
    check("rst no_done", 32'(ndone), 32'd0);
    run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "post_rst");

    // Back-to-back with START held high
    @(negedge CLK);
    A = 8'h5A; B = 8'h3C; BIN = 1'b0; START = 1'b1;
    for (int i = 0; i < 4*(W+2) + 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (DONE) begin
        dones.push_back(i);
        check($sformatf("b2b diff%0d", dones.size()), 32'(DIFF), 32'h1E);
      end
      lowv[i] = !BUSY;
    end
    START = 1'b0;
    check("b2b done_count", 32'(dones.size() >= 3), 32'd1);
    if (dones.size() >= 2) begin
      for (int j = 1; j < dones.size(); j++)
        check($sformatf("b2b period%0d", j), 32'(dones[j] - dones[j-1]), 32'(W + 2));
      lows = 0;
      for (int i = dones[0]; i < dones[dones.size()-1]; i++) if (lowv[i]) lows++;
      check("b2b busy_low", 32'(lows), 32'(dones.size() - 1));
    end
    repeat (W + 3) @(posedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port START  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  minuend; captured on the accepted START edge.
REQ-006 SHALL have port B  input  WIDTH  subtrahend; captured on the accepted START edge.
REQ-007 SHALL have port BIN  input  1  borrow-in; captured on the accepted START edge.
REQ-008 SHALL have port DIFF  output  WIDTH  registered result A-B-BIN mod 2^WIDTH.
REQ-009 SHALL have port BOUT  output  1  registered borrow-out; 1 when A < B+BIN (unsigned).
REQ-010 SHALL have port BUSY  output  1  high while an operation is in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle pulse; DIFF/BOUT valid from this cycle.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, FIN.
REQ-013 IDLE: START=1 on an edge SHALL load A, B into internal shift registers, BIN into the borrow flop, clear the bit counter, go to SHIFT.
REQ-014 SHIFT: each cycle SHALL apply one 1-bit full subtraction to operand LSBs and the borrow flop, shift the difference bit into the MSB of the result shift register, shift both operands right by one, update the borrow flop, increment the counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then go to FIN.
REQ-016 FIN SHALL copy the result shift register to DIFF and the borrow flop to BOUT, assert DONE for that one cycle, then return to IDLE.
REQ-017 Latency: with START sampled on edge 0, DONE SHALL be high during the cycle after edge WIDTH+1; a new START SHALL be accepted on the following edge.
REQ-018 BUSY SHALL be 1 in SHIFT and FIN, 0 in IDLE.
REQ-019 START while BUSY=1 SHALL be ignored; no operand recapture, no restart.
REQ-020 DIFF and BOUT SHALL hold their last result until the next FIN; they SHALL NOT change during SHIFT.
REQ-021 Per-bit arithmetic SHALL be d = a^b^br, br_next = (~a&b) | (~a&br) | (b&br).
REQ-022 Operand changes on A/B/BIN after capture SHALL NOT affect the result.

Reset
REQ-023 RST=1 SHALL force, without a clock edge, FSM to IDLE, DIFF=0, BOUT=0, BUSY=0, DONE=0, counter, borrow flop and shift registers to 0.
REQ-024 RST asserted mid-operation SHALL abort it; no DONE pulse SHALL follow; first START after RST release SHALL start a fresh operation.

Structure
REQ-025 FSM state encoding type and the counter width constant (clog2(WIDTH+1)) SHALL live in a shared package serial_arith_pkg.
REQ-026 The per-bit combinational cell SHALL be a separate sub-module full_sub_1bit (inputs A, B, Bin; outputs D, Bout), instantiated once.

Verification
REQ-027 WIDTH=8, A=0x35, B=0x12, BIN=0, START one cycle -> DONE pulse 10 cycles after START edge, DIFF=0x23, BOUT=0.
REQ-028 A=0x00, B=0x01, BIN=0 -> DIFF=0xFF, BOUT=1.
REQ-029 A=0x80, B=0x80, BIN=1 -> DIFF=0xFF, BOUT=1; A=0xFF, B=0x00, BIN=1 -> DIFF=0xFE, BOUT=0.
REQ-030 A=0x10, B=0x01 started; START pulsed with A=0x00, B=0x00 at cycle 3 -> ignored, DIFF=0x0F, exactly one DONE.
REQ-031 Start A=0x55, B=0x22; assert RST at cycle 4 -> BUSY=0, DIFF=0 immediately, no DONE; then A=0x09, B=0x04 -> DIFF=0x05, BOUT=0.
REQ-032 Back-to-back: START held high continuously with fixed operands -> one DONE every WIDTH+2 cycles, BUSY low exactly one cycle between operations.
